// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer: directions, FSM states, grid geometry.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int unsigned GRID_SIZE = 16;

    // Opposite directions differ only in bit 1 of the encoding.
    function automatic logic is_reverse(input dir_t cur, input logic [1:0] req);
        return req == (cur ^ 2'd2);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Vsync rising-edge detector plus frame divider; step_due pulses once per FRAMES_PER_STEP frames.
module frame_tick_gen #(
    parameter int unsigned FRAMES_PER_STEP = 8
) (
    input  logic pclk,
    input  logic rst,
    input  logic vsync_in,
    input  logic enable,
    output logic step_due
);

    logic       vsync_d;
    logic       frame_rise;
    logic [7:0] frame_cnt;

    assign frame_rise = vsync_in & ~vsync_d;
    assign step_due   = enable & frame_rise & (frame_cnt == 8'(FRAMES_PER_STEP - 1));

    // Counter is parked at zero while disabled so every enable starts a full period.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_d   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vsync_d <= vsync_in;
            if (!enable || step_due) begin
                frame_cnt <= '0;
            end else if (frame_rise) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake game sequencer: divides vsync into movement steps, latches direction requests,
// advances the head one grid cell per step and ends the game on leaving the playfield.
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned START_X         = 32,
    parameter int unsigned START_Y         = 24
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic [6:0] frame_x_inside_grid,
    input  logic [5:0] frame_y_inside_grid,
    input  logic [6:0] number_x_grid,
    input  logic [5:0] number_y_grid,
    input  logic       start,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    output logic [6:0] head_x,
    output logic [5:0] head_y,
    output logic [1:0] dir_out,
    output logic       move_strobe,
    output logic       game_over,
    output logic       running
);

    state_t     state, state_nxt;
    dir_t       dir, dir_nxt;
    logic [6:0] head_x_nxt;
    logic [5:0] head_y_nxt;
    logic       strobe_nxt;
    logic       step_due;

    logic [6:0] x_min, x_max;
    logic [5:0] y_min, y_max;
    logic [7:0] next_x;
    logic [6:0] next_y;
    logic       in_bounds;
    logic       dir_accept;

    assign x_min = frame_x_inside_grid;
    assign x_max = number_x_grid - frame_x_inside_grid - 7'd1;
    assign y_min = frame_y_inside_grid;
    assign y_max = number_y_grid - frame_y_inside_grid - 6'd1;

    frame_tick_gen #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_tick (
        .pclk    (pclk),
        .rst     (rst),
        .vsync_in(vsync_in),
        .enable  (state == RUN),
        .step_due(step_due)
    );

    // Candidate position is one bit wider so 0-1 and max+1 land outside the bounds.
    always_comb begin
        next_x = {1'b0, head_x};
        next_y = {1'b0, head_y};
        case (dir)
            DIR_UP:    next_y = next_y - 7'd1;
            DIR_RIGHT: next_x = next_x + 8'd1;
            DIR_DOWN:  next_y = next_y + 7'd1;
            DIR_LEFT:  next_x = next_x - 8'd1;
            default:   next_x = {1'b0, head_x};
        endcase
        in_bounds = (next_x >= {1'b0, x_min}) && (next_x <= {1'b0, x_max}) &&
                    (next_y >= {1'b0, y_min}) && (next_y <= {1'b0, y_max});
    end

    assign dir_accept = dir_valid && (state != OVER) && !is_reverse(dir, dir_req);

    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir;
        head_x_nxt = head_x;
        head_y_nxt = head_y;
        strobe_nxt = 1'b0;

        if (dir_accept) begin
            dir_nxt = dir_t'(dir_req);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (step_due) begin
                    if (in_bounds) begin
                        head_x_nxt = next_x[6:0];
                        head_y_nxt = next_y[5:0];
                        strobe_nxt = 1'b1;
                    end else begin
                        state_nxt = OVER;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    state_nxt  = RUN;
                    head_x_nxt = 7'(START_X);
                    head_y_nxt = 6'(START_Y);
                    dir_nxt    = DIR_RIGHT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= IDLE;
            dir         <= DIR_RIGHT;
            head_x      <= 7'(START_X);
            head_y      <= 6'(START_Y);
            move_strobe <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir         <= dir_nxt;
            head_x      <= head_x_nxt;
            head_y      <= head_y_nxt;
            move_strobe <= strobe_nxt;
        end
    end

    assign dir_out   = dir;
    assign game_over = (state == OVER);
    assign running   = (state == RUN);

endmodule
